// File: rtl/ssram_responder.sv
// Synchronous-burst SRAM target: decodes the pipelined SSRAM bus, runs the 2-bit burst counter
// and serves a byte-writable array. Define SSRAM_INTERLEAVE_EN for interleaved burst order.
module ssram_responder #(
    parameter int ADDR_W = 14
) (
    input  logic        sys_clk,
    input  logic        xresetl,
    input  logic        ssram_ce1_n,
    input  logic        ssram_ce2,
    input  logic        ssram_ce3_n,
    input  logic        ssram_adsc_n,
    input  logic        ssram_adsp_n,
    input  logic        ssram_adv_n,
    input  logic        ssram_oe_n,
    input  logic        ssram_bwe_n,
    input  logic        ssram_gw_n,
    input  logic [3:0]  ssram_be_n,
    input  logic [20:0] ssram_addr,
    input  logic [31:0] ssram_d,
    output logic [31:0] ssram_q,
    output logic        ssram_q_oe
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              selected_q, selected_d;

    logic              sel_cyc;
    logic              load;
    logic              deselect;
    logic              wr_en;
    logic [3:0]        lane_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    function automatic logic [1:0] burst_idx(input logic [1:0] start, input logic [1:0] cnt);
`ifdef SSRAM_INTERLEAVE_EN
        return start ^ cnt;
`else
        return start + cnt;
`endif
    endfunction

    always_comb begin
        sel_cyc    = ~ssram_ce1_n & ssram_ce2 & ~ssram_ce3_n;
        load       = sel_cyc & (~ssram_adsc_n | ~ssram_adsp_n);
        deselect   = ~ssram_adsc_n & ~sel_cyc;

        base_d     = base_q;
        cnt_d      = cnt_q;
        selected_d = selected_q;

        if (load) begin
            base_d     = ssram_addr[ADDR_W-1:0];
            cnt_d      = 2'd0;
            selected_d = 1'b1;
        end else begin
            if (!ssram_adv_n) begin
                cnt_d = cnt_q + 2'd1;
            end
            if (deselect) begin
                selected_d = 1'b0;
            end
        end
    end

    // Reads use the address before this edge; writes land on the post-advance beat.
    assign rd_addr = {base_q[ADDR_W-1:2], burst_idx(base_q[1:0], cnt_q)};
    assign wr_addr = {base_q[ADDR_W-1:2], burst_idx(base_q[1:0], cnt_d)};
    assign wr_en   = selected_q & ~load & (~ssram_gw_n | ~ssram_bwe_n);

    always_ff @(posedge sys_clk or negedge xresetl) begin
        if (!xresetl) begin
            base_q     <= '0;
            cnt_q      <= 2'd0;
            selected_q <= 1'b0;
        end else begin
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            selected_q <= selected_d;
        end
    end

    // One byte-wide array per lane so each lane maps onto its own write-enabled RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_q;

            assign lane_we[gi] = wr_en & (~ssram_gw_n | ~ssram_be_n[gi]);

            always_ff @(posedge sys_clk) begin
                if (lane_we[gi]) begin
                    mem[wr_addr] <= ssram_d[8*gi +: 8];
                end
            end

            always_ff @(posedge sys_clk or negedge xresetl) begin
                if (!xresetl) begin
                    rd_byte_q <= 8'h00;
                end else begin
                    rd_byte_q <= mem[rd_addr];
                end
            end

            assign ssram_q[8*gi +: 8] = rd_byte_q;
        end

        if (ADDR_W < 21) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^ssram_addr[20:ADDR_W];
        end
    endgenerate

    assign ssram_q_oe = selected_q & ~ssram_oe_n & ssram_bwe_n & ssram_gw_n;

endmodule

// File: tb/tb_ssram_responder.sv
// Bench for ssram_responder: directed per-cycle vector table for the bus scenarios,
// then randomized bus traffic checked against a byte-level memory model.
module tb_ssram_responder;

    localparam int ADDR_W = 14;

    logic        sys_clk;
    logic        xresetl;
    logic        ssram_ce1_n, ssram_ce2, ssram_ce3_n;
    logic        ssram_adsc_n, ssram_adsp_n, ssram_adv_n;
    logic        ssram_oe_n, ssram_bwe_n, ssram_gw_n;
    logic [3:0]  ssram_be_n;
    logic [20:0] ssram_addr;
    logic [31:0] ssram_d;
    logic [31:0] ssram_q;
    logic        ssram_q_oe;

    ssram_responder #(.ADDR_W(ADDR_W)) dut (
        .sys_clk     (sys_clk),
        .xresetl     (xresetl),
        .ssram_ce1_n (ssram_ce1_n),
        .ssram_ce2   (ssram_ce2),
        .ssram_ce3_n (ssram_ce3_n),
        .ssram_adsc_n(ssram_adsc_n),
        .ssram_adsp_n(ssram_adsp_n),
        .ssram_adv_n (ssram_adv_n),
        .ssram_oe_n  (ssram_oe_n),
        .ssram_bwe_n (ssram_bwe_n),
        .ssram_gw_n  (ssram_gw_n),
        .ssram_be_n  (ssram_be_n),
        .ssram_addr  (ssram_addr),
        .ssram_d     (ssram_d),
        .ssram_q     (ssram_q),
        .ssram_q_oe  (ssram_q_oe)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic        ce1_n;
        logic        adsc_n;
        logic        adsp_n;
        logic        adv_n;
        logic        oe_n;
        logic        bwe_n;
        logic        gw_n;
        logic [3:0]  be_n;
        logic [20:0] addr;
        logic [31:0] d;
        bit          chk_q;
        logic [31:0] exp_q;
        logic        exp_oe;
        bit          rst_after;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic ce1_n, logic adsc_n, logic adsp_n, logic adv_n,
                                logic oe_n, logic bwe_n, logic gw_n, logic [3:0] be_n,
                                logic [20:0] addr, logic [31:0] d, bit chk_q,
                                logic [31:0] exp_q, logic exp_oe, bit rst_after);
        vec_t v;
        v.name = nm;   v.ce1_n = ce1_n; v.adsc_n = adsc_n; v.adsp_n = adsp_n;
        v.adv_n = adv_n; v.oe_n = oe_n; v.bwe_n = bwe_n; v.gw_n = gw_n;
        v.be_n = be_n; v.addr = addr;   v.d = d;         v.chk_q = chk_q;
        v.exp_q = exp_q; v.exp_oe = exp_oe; v.rst_after = rst_after;
        return v;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        ssram_ce1_n = 1'b0; ssram_ce2 = 1'b1; ssram_ce3_n = 1'b0;
        ssram_adsc_n = 1'b1; ssram_adsp_n = 1'b1; ssram_adv_n = 1'b1;
        ssram_oe_n = 1'b0; ssram_bwe_n = 1'b1; ssram_gw_n = 1'b1;
        ssram_be_n = 4'hF; ssram_addr = '0; ssram_d = '0;
    endtask

    task automatic drive(vec_t v);
        ssram_ce1_n = v.ce1_n; ssram_ce2 = 1'b1; ssram_ce3_n = 1'b0;
        ssram_adsc_n = v.adsc_n; ssram_adsp_n = v.adsp_n; ssram_adv_n = v.adv_n;
        ssram_oe_n = v.oe_n; ssram_bwe_n = v.bwe_n; ssram_gw_n = v.gw_n;
        ssram_be_n = v.be_n; ssram_addr = v.addr; ssram_d = v.d;
    endtask

    task automatic pulse_reset(string nm);
        xresetl = 1'b0;
        #1;
        check({nm, "_rst_q"}, ssram_q, 32'h0);
        check({nm, "_rst_oe"}, {31'b0, ssram_q_oe}, 32'h0);
        #1;
        xresetl = 1'b1;
    endtask

    // Reference model: word address of beat k of a burst starting at b.
    function automatic int beat_addr(int b, int k);
`ifdef SSRAM_INTERLEAVE_EN
        return (b & ~3) | ((b & 3) ^ k);
`else
        return (b & ~3) | (((b & 3) + k) % 4);
`endif
    endfunction

    logic [31:0] m_mem [int];
    logic [3:0]  m_vld [int];
    int          m_base, m_k;
    bit          m_sel;

    localparam logic [31:0] A0 = 32'hA0A0_0F00, A1 = 32'hA1A1_1F11;
    localparam logic [31:0] A2 = 32'hA2A2_2F22, A3 = 32'hA3A3_3F33;

    initial begin : main
        logic [31:0] k1, k2, k3;
`ifdef SSRAM_INTERLEAVE_EN
        k1 = A2; k2 = A1; k3 = A0;
`else
        k1 = A0; k2 = A1; k3 = A2;
`endif

        // Reset state with clocks running.
        set_idle();
        xresetl = 1'b0;
        repeat (3) tick();
        check("reset_q", ssram_q, 32'h0);
        check("reset_oe", {31'b0, ssram_q_oe}, 32'h0);
        xresetl = 1'b1;

        //                 name         ce1 adsc adsp adv oe bwe gw  be_n   addr     d             chk exp_q         oe rst
        vecs.push_back(mk("pre_ld201",  0,  0,   1,   1,  1, 1,  1, 4'hF, 21'h201, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk("pre_wr201",  0,  1,   1,   1,  1, 1,  0, 4'hF, 21'h0,   32'hCAFEF00D, 0, 32'h0,        0, 0));
        vecs.push_back(mk("pre_ld100",  0,  0,   1,   1,  1, 1,  1, 4'hF, 21'h100, 32'h0,        1, 32'hCAFEF00D, 0, 0));
        vecs.push_back(mk("pre_wr100",  0,  1,   1,   1,  1, 1,  0, 4'hF, 21'h0,   32'hDEADBEEF, 0, 32'h0,        0, 0));
        vecs.push_back(mk("pre_wr101",  0,  1,   1,   0,  1, 1,  0, 4'hF, 21'h0,   32'h12345678, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk("rd_e1",      0,  0,   1,   1,  1, 1,  1, 4'hF, 21'h100, 32'h0,        1, 32'h12345678, 0, 0));
        vecs.push_back(mk("rd_e2",      0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk("rd_e3",      0,  1,   1,   1,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, 32'h12345678, 1, 0));
        vecs.push_back(mk("rd_e4",      0,  1,   1,   1,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, 32'h12345678, 1, 0));
        vecs.push_back(mk("wr_e1_adsp", 0,  1,   0,   1,  1, 0,  1, 4'h0, 21'h200, 32'hFFFFFFFF, 1, 32'h12345678, 0, 0));
        vecs.push_back(mk("wr_e2",      0,  1,   1,   1,  0, 0,  1, 4'h0, 21'h0,   32'hAABBCCDD, 0, 32'h0,        0, 0));
        vecs.push_back(mk("wr_e3",      0,  1,   1,   1,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, 32'hAABBCCDD, 1, 0));
        vecs.push_back(mk("wr_e4_be",   0,  1,   1,   0,  0, 0,  1, 4'h3, 21'h0,   32'h11223344, 1, 32'hAABBCCDD, 0, 0));
        vecs.push_back(mk("wr_e5",      0,  1,   1,   1,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, 32'h1122F00D, 1, 0));
        vecs.push_back(mk("b_ld0",      0,  0,   1,   1,  1, 1,  1, 4'hF, 21'h000, 32'h0,        1, 32'h1122F00D, 0, 0));
        vecs.push_back(mk("b_w0",       0,  1,   1,   1,  1, 1,  0, 4'hF, 21'h0,   A0,           0, 32'h0,        0, 0));
        vecs.push_back(mk("b_w1",       0,  1,   1,   0,  1, 1,  0, 4'hF, 21'h0,   A1,           1, A0,           0, 0));
        vecs.push_back(mk("b_w2",       0,  1,   1,   0,  1, 1,  0, 4'hF, 21'h0,   A2,           1, A1,           0, 0));
        vecs.push_back(mk("b_w3",       0,  1,   1,   0,  1, 1,  0, 4'hF, 21'h0,   A3,           1, A2,           0, 0));
        vecs.push_back(mk("b_ld3",      0,  0,   1,   1,  0, 1,  1, 4'hF, 21'h003, 32'h0,        1, A3,           1, 0));
        vecs.push_back(mk("b_beat0",    0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, A3,           1, 0));
        vecs.push_back(mk("b_beat1",    0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, k1,           1, 0));
        vecs.push_back(mk("b_beat2",    0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, k2,           1, 0));
        vecs.push_back(mk("b_beat3",    0,  1,   1,   1,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, k3,           1, 0));
        vecs.push_back(mk("ds_adsc",    1,  0,   1,   1,  0, 1,  1, 4'hF, 21'h000, 32'h0,        1, k3,           0, 0));
        vecs.push_back(mk("ds_wr_adv",  0,  1,   1,   0,  0, 0,  0, 4'h0, 21'h0,   32'hBAD0BAD0, 1, k3,           0, 0));
        vecs.push_back(mk("ds_wr",      0,  1,   1,   1,  0, 0,  1, 4'h0, 21'h0,   32'hBAD0BAD0, 1, A3,           0, 0));
        vecs.push_back(mk("ds_idle",    0,  1,   1,   1,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, A3,           0, 0));
        vecs.push_back(mk("ds_reld3",   0,  0,   1,   1,  0, 1,  1, 4'hF, 21'h003, 32'h0,        1, A3,           1, 0));
        vecs.push_back(mk("ds_beat0",   0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, A3,           1, 0));
        vecs.push_back(mk("ds_beat1",   0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, k1,           1, 0));
        vecs.push_back(mk("rbw_ld",     0,  0,   1,   1,  0, 1,  1, 4'hF, 21'h100, 32'h0,        1, A1,           1, 0));
        vecs.push_back(mk("rbw_wr",     0,  1,   1,   1,  0, 1,  0, 4'hF, 21'h0,   32'h55555555, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk("rbw_rd",     0,  1,   1,   1,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, 32'h55555555, 1, 0));
        vecs.push_back(mk("ra_ld",      0,  0,   1,   1,  0, 1,  1, 4'hF, 21'h200, 32'h0,        1, 32'h55555555, 1, 0));
        vecs.push_back(mk("ra_e2",      0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, 32'hAABBCCDD, 1, 1));
        vecs.push_back(mk("ra_e3",      0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, A0,           0, 0));
        vecs.push_back(mk("ra_e4",      0,  1,   1,   0,  0, 1,  1, 4'hF, 21'h0,   32'h0,        1, A1,           0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            if (vecs[i].chk_q) check({vecs[i].name, "_q"}, ssram_q, vecs[i].exp_q);
            check({vecs[i].name, "_oe"}, {31'b0, ssram_q_oe}, {31'b0, vecs[i].exp_oe});
            $display("vec %-11s q=%h q_oe=%b", vecs[i].name, ssram_q, ssram_q_oe);
            if (vecs[i].rst_after) pulse_reset(vecs[i].name);
        end

        // Randomized traffic in a 16-word window, model starts from reset state.
        set_idle();
        pulse_reset("rand_start");
        m_base = 0; m_k = 0; m_sel = 0;
        for (int c = 0; c < 400; c++) begin
            bit          sel, ld;
            int          rd, wa;
            logic [31:0] exp_q, mask;
            logic [3:0]  vld;

            ssram_ce1_n  = ($urandom_range(0, 7) == 0);
            ssram_ce2    = ($urandom_range(0, 7) != 0);
            ssram_ce3_n  = ($urandom_range(0, 7) == 0);
            ssram_adsc_n = ($urandom_range(0, 5) != 0);
            ssram_adsp_n = ($urandom_range(0, 5) != 0);
            ssram_adv_n  = $urandom_range(0, 1);
            ssram_oe_n   = $urandom_range(0, 1);
            ssram_gw_n   = ($urandom_range(0, 3) != 0);
            ssram_bwe_n  = ($urandom_range(0, 2) != 0);
            ssram_be_n   = 4'($urandom);
            ssram_addr   = {7'($urandom), 14'(14'h3F0 + $urandom_range(0, 15))};
            ssram_d      = $urandom;

            sel = !ssram_ce1_n && ssram_ce2 && !ssram_ce3_n;
            ld  = sel && (!ssram_adsc_n || !ssram_adsp_n);
            rd  = beat_addr(m_base, m_k);
            exp_q = m_mem.exists(rd) ? m_mem[rd] : 32'h0;
            vld   = m_vld.exists(rd) ? m_vld[rd] : 4'h0;
            if (ld) m_k = 0;
            else if (!ssram_adv_n) m_k = (m_k + 1) % 4;
            if (m_sel && !ld && (!ssram_gw_n || !ssram_bwe_n)) begin
                wa = beat_addr(m_base, m_k);
                if (!m_mem.exists(wa)) begin m_mem[wa] = 32'h0; m_vld[wa] = 4'h0; end
                for (int l = 0; l < 4; l++) begin
                    if (!ssram_gw_n || !ssram_be_n[l]) begin
                        m_mem[wa][8*l +: 8] = ssram_d[8*l +: 8];
                        m_vld[wa][l] = 1'b1;
                    end
                end
            end
            if (ld) begin
                m_base = int'(ssram_addr[ADDR_W-1:0]);
                m_sel  = 1;
            end else if (!ssram_adsc_n && !sel) begin
                m_sel = 0;
            end

            tick();
            mask = {{8{vld[3]}}, {8{vld[2]}}, {8{vld[1]}}, {8{vld[0]}}};
            if (vld != 4'h0) check("rand_q", ssram_q & mask, exp_q & mask);
            check("rand_oe", {31'b0, ssram_q_oe},
                  {31'b0, m_sel && !ssram_oe_n && ssram_bwe_n && ssram_gw_n});
            $display("rand %0d addr=%h q=%h q_oe=%b", c, rd, ssram_q, ssram_q_oe);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ssram_responder.md
SSRAM_RESPONDER -- requirements
Module: ssram_responder

Interface
REQ-001 Parameter ADDR_W, default 14, 32-bit word-address width of the internal array (2^ADDR_W words).
REQ-002 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 xresetl  in  1  reset, asynchronous, active-low.
REQ-004 ssram_ce1_n / ssram_ce2 / ssram_ce3_n  in  1 each  chip enables (active low / high / low).
REQ-005 ssram_adsc_n / ssram_adsp_n  in  1 each  controller-side / processor-side address strobes, active low.
REQ-006 ssram_adv_n  in  1  burst advance, active low.
REQ-007 ssram_oe_n  in  1  output enable, active low, asynchronous.
REQ-008 ssram_bwe_n / ssram_gw_n  in  1 each  byte-write enable / global write, active low.
REQ-009 ssram_be_n  in  4  byte lane enables, active low; bit n gates bits 8n+7:8n.
REQ-010 ssram_addr  in  21  word address; bits ADDR_W-1:0 used, bits 1:0 are the burst start.
REQ-011 ssram_d  in  32  write data from initiator.
REQ-012 ssram_q  out  32  read data (registered).
REQ-013 ssram_q_oe  out  1  read-data drive enable for the external tristate.

Function
REQ-014 sel_cyc = ~ce1_n & ce2 & ~ce3_n, evaluated each edge.
REQ-015 Load: at an edge with sel_cyc & (~adsc_n | ~adsp_n): base <= ssram_addr[ADDR_W-1:0], cnt <= 0, selected <= 1.
REQ-016 Deselect: at an edge with ~adsc_n & ~sel_cyc: selected <= 0; ~adsp_n with ~sel_cyc is ignored.
REQ-017 Advance: at an edge with no load and ~adv_n: cnt <= cnt + 1, 2-bit, wraps 3->0; adv_n with no load and adv_n high holds cnt.
REQ-018 Effective address eff = {base[ADDR_W-1:2], burst(base[1:0], cnt)}; upper bits never carry.
REQ-019 Write: at an edge with selected & no load & (~gw_n | ~bwe_n), array word at eff-after-this-edge's-advance written; gw_n low writes all 4 bytes, else only lanes with be_n low.
REQ-020 Writes during a load edge (including adsp_n) are discarded.
REQ-021 Read pipeline: every edge, ssram_q <= array[eff] using eff before this edge's update; read-before-write when write targets same word.
REQ-022 Read latency: address loaded at edge E1 -> word valid on ssram_q from E2 to E3; ADV at E2 -> next word valid E3 to E4.
REQ-023 ssram_q_oe = selected & ~oe_n & bwe_n & gw_n, combinational.
REQ-024 Array contents are not reset and are not altered by reset.

Reset
REQ-025 xresetl low asynchronously forces base=0, cnt=0, selected=0, ssram_q=0, hence ssram_q_oe=0.
REQ-026 Reset asserted mid-burst aborts the burst; first access after release requires a new load.
REQ-027 Write attempted in the same cycle reset is asserted is discarded.

Configuration
REQ-028 Macro SSRAM_INTERLEAVE_EN defined: burst(a,c) = a XOR c (interleaved order, e.g. start 1 -> 1,0,3,2).
REQ-029 Macro SSRAM_INTERLEAVE_EN undefined: burst(a,c) = (a + c) mod 4 (linear order, e.g. start 1 -> 1,2,3,0).

Verification
REQ-030 Preload word 0x0100=0xDEADBEEF, 0x0101=0x12345678; ADSC+CE at E1 addr 0x0100, ADV at E2, OE low E2-E5 -> ssram_q 0xDEADBEEF during E2-E3, 0x12345678 during E3-E4, q_oe high.
REQ-031 ADSP+CE at E1 addr 0x0200; BWE low, be_n=0000, d=0xAABBCCDD at E2; BWE+ADV, be_n=0011, d=0x11223344 at E4 -> word 0x0200=0xAABBCCDD, 0x0201 bytes 3:2=0x1122, bytes 1:0 unchanged.
REQ-032 Start addr 0x0003, ADV on 3 consecutive edges -> linear: 0x0003,0x0000,0x0001,0x0002; with SSRAM_INTERLEAVE_EN: 0x0003,0x0002,0x0001,0x0000.
REQ-033 ADSC with ce1_n high after active burst -> q_oe stays 0 with oe_n low; following BWE writes leave array unchanged.
REQ-034 xresetl pulsed low between E2 and E3 of read burst -> ssram_q=0, q_oe=0 immediately; ADV after release does not resume burst.
REQ-035 Write 0x55555555 and read same word at same edge -> ssram_q shows old value; next read returns 0x55555555.
